// File: rtl/px_readout_sequencer.sv
// Frame-readout sequencer: scans NUM_ROWS x NUM_COLS pixels through
// array reset, per-pixel settle, ADC convert handshake and row/column advance.
//
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   start_cap, abort    capture request (IDLE only) / abort (any state)
//   fifo_afull          blocks the next conversion while high
//   adc_done            conversion finished pulse from the capture engine
//   adc_start           one-cycle conversion request
//   resp, resv          pixel / vertical reset strobes
//   incp, incv          column / row advance strobes
//   inphi               sample phase (SETTLE, CONV, WAIT_ADC)
//   busy, frame_done    activity flag / end-of-frame pulse
//   timeout_err         sticky ADC timeout flag
//   row_idx, col_idx    current pixel position
//   state_out           FSM state encoding
module px_readout_sequencer #(
    parameter int NUM_ROWS      = 112,
    parameter int NUM_COLS      = 112,
    parameter int SETTLE_CYCLES = 8,
    parameter int PULSE_CYCLES  = 2,
    parameter int ADC_TIMEOUT   = 255,
    parameter int CNT_W         = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start_cap,
    input  logic             abort,
    input  logic             fifo_afull,
    input  logic             adc_done,
    output logic             adc_start,
    output logic             resp,
    output logic             resv,
    output logic             incp,
    output logic             incv,
    output logic             inphi,
    output logic             busy,
    output logic             frame_done,
    output logic             timeout_err,
    output logic [CNT_W-1:0] row_idx,
    output logic [CNT_W-1:0] col_idx,
    output logic [2:0]       state_out
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_RST    = 3'd1;
    localparam logic [2:0] S_SETTLE = 3'd2;
    localparam logic [2:0] S_CONV   = 3'd3;
    localparam logic [2:0] S_WAIT   = 3'd4;
    localparam logic [2:0] S_COL    = 3'd5;
    localparam logic [2:0] S_ROW    = 3'd6;
    localparam logic [2:0] S_DONE   = 3'd7;

    localparam logic [CNT_W-1:0] PULSE_LAST  = CNT_W'(PULSE_CYCLES - 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] TO_LAST     = CNT_W'(ADC_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] COL_LAST    = CNT_W'(NUM_COLS - 1);
    localparam logic [CNT_W-1:0] ROW_LAST    = CNT_W'(NUM_ROWS - 1);
    localparam logic [CNT_W-1:0] ONE         = CNT_W'(1);

    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] tmr_q, tmr_d;
    logic [CNT_W-1:0] row_q, row_d;
    logic [CNT_W-1:0] col_q, col_d;
    logic             terr_q, terr_d;

    logic pulse_end;
    logic settle_end;

    assign pulse_end  = (tmr_q == PULSE_LAST);
    // SETTLE may be held past expiry by fifo_afull; the timer saturates
    assign settle_end = (tmr_q >= SETTLE_LAST);

    always_comb begin
        state_d = state_q;
        tmr_d   = tmr_q;
        row_d   = row_q;
        col_d   = col_q;
        terr_d  = terr_q;

        if (abort) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start_cap) begin
                        state_d = S_RST;
                        row_d   = '0;
                        col_d   = '0;
                        terr_d  = 1'b0;
                    end
                end
                S_RST: begin
                    if (pulse_end) state_d = S_SETTLE;
                end
                S_SETTLE: begin
                    if (settle_end && !fifo_afull) state_d = S_CONV;
                end
                S_CONV: begin
                    state_d = S_WAIT;
                end
                S_WAIT: begin
                    // adc_done wins over a timeout on the same cycle
                    if (adc_done) begin
                        if (col_q != COL_LAST)      state_d = S_COL;
                        else if (row_q != ROW_LAST) state_d = S_ROW;
                        else                        state_d = S_DONE;
                    end else if (tmr_q == TO_LAST) begin
                        state_d = S_IDLE;
                        terr_d  = 1'b1;
                    end
                end
                S_COL: begin
                    if (pulse_end) begin
                        state_d = S_SETTLE;
                        col_d   = col_q + ONE;
                    end
                end
                S_ROW: begin
                    if (pulse_end) begin
                        state_d = S_SETTLE;
                        col_d   = '0;
                        row_d   = row_q + ONE;
                    end
                end
                S_DONE: begin
                    state_d = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end

        // one shared timer, restarted on every state change
        if (state_d != state_q) begin
            tmr_d = '0;
        end else if (tmr_q != '1) begin
            tmr_d = tmr_q + ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            tmr_q   <= '0;
            row_q   <= '0;
            col_q   <= '0;
            terr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            tmr_q   <= tmr_d;
            row_q   <= row_d;
            col_q   <= col_d;
            terr_q  <= terr_d;
        end
    end

    assign resp        = (state_q == S_RST);
    assign resv        = (state_q == S_RST);
    assign incp        = (state_q == S_COL);
    assign incv        = (state_q == S_ROW);
    assign inphi       = (state_q == S_SETTLE) || (state_q == S_CONV) ||
                         (state_q == S_WAIT);
    assign adc_start   = (state_q == S_CONV);
    assign busy        = (state_q != S_IDLE);
    assign frame_done  = (state_q == S_DONE);
    assign timeout_err = terr_q;
    assign row_idx     = row_q;
    assign col_idx     = col_q;
    assign state_out   = state_q;

endmodule

// File: tb/tb_px_readout_sequencer.sv
// Bench for px_readout_sequencer: a phase-level frame model builds the
// stimulus and expected per-cycle trace, then the DUT is replayed against it.
module tb_px_readout_sequencer;

    localparam int NR   = 2;
    localparam int NC   = 3;
    localparam int SET  = 4;
    localparam int PUL  = 2;
    localparam int TO   = 10;
    localparam int W    = 8;
    localparam int NPIX = NR * NC;
    localparam int MAXT = 3000;

    localparam int P_IDLE = 0;
    localparam int P_RST  = 1;
    localparam int P_SET  = 2;
    localparam int P_CONV = 3;
    localparam int P_WAIT = 4;
    localparam int P_COL  = 5;
    localparam int P_ROW  = 6;
    localparam int P_DONE = 7;

    logic         clk = 1'b0;
    logic         reset, start_cap, abort, fifo_afull, adc_done;
    logic         adc_start, resp, resv, incp, incv, inphi;
    logic         busy, frame_done, timeout_err;
    logic [W-1:0] row_idx, col_idx;
    logic [2:0]   state_out;

    always #5 clk = ~clk;

    px_readout_sequencer #(
        .NUM_ROWS(NR), .NUM_COLS(NC), .SETTLE_CYCLES(SET),
        .PULSE_CYCLES(PUL), .ADC_TIMEOUT(TO), .CNT_W(W)
    ) dut (
        .clk(clk), .reset(reset), .start_cap(start_cap), .abort(abort),
        .fifo_afull(fifo_afull), .adc_done(adc_done),
        .adc_start(adc_start), .resp(resp), .resv(resv), .incp(incp),
        .incv(incv), .inphi(inphi), .busy(busy), .frame_done(frame_done),
        .timeout_err(timeout_err), .row_idx(row_idx), .col_idx(col_idx),
        .state_out(state_out)
    );

    bit st_a[MAXT], ab_a[MAXT], af_a[MAXT], dn_a[MAXT], rs_a[MAXT];
    int ex_ph[MAXT], ex_row[MAXT], ex_col[MAXT];
    bit ex_terr[MAXT];

    int t, m_row, m_col;
    bit m_terr, noise;
    int dly[NPIX];
    int n_assert, n_fail;
    int f1_s, f1_e;

    task automatic emit(input int ph);
        if (t < MAXT) begin
            ex_ph[t]   = ph;
            ex_row[t]  = m_row;
            ex_col[t]  = m_col;
            ex_terr[t] = m_terr;
            // start_cap while busy must be ignored
            if (noise && ph != P_IDLE && $urandom_range(5) == 0) st_a[t] = 1'b1;
        end
        t++;
    endtask

    task automatic idle(input int n);
        repeat (n) emit(P_IDLE);
    endtask

    // mode: 0 none, 1 abort in ROW_INC, 2 abort with adc_done, 3 reset in SETTLE
    task automatic gen_frame(input int mode, input int mpix, input int hold_pix);
        st_a[t] = 1'b1;
        emit(P_IDLE);
        m_row = 0; m_col = 0; m_terr = 1'b0;
        repeat (PUL) emit(P_RST);
        for (int p = 0; p < NPIX; p++) begin
            int k, last, d;
            k = 0;
            if (mode == 3 && p == mpix) begin
                rs_a[t] = 1'b1;
                emit(P_SET);
                m_row = 0; m_col = 0; m_terr = 1'b0;
                return;
            end
            do begin
                if (p == hold_pix && k == 0)
                    for (int i = 0; i < 20; i++) af_a[t + i] = 1'b1;
                if (noise && $urandom_range(2) == 0) dn_a[t] = 1'b1;
                last = t;
                k++;
                emit(P_SET);
            end while (!(k >= SET && !af_a[last]));
            emit(P_CONV);
            d = dly[p];
            if (mode == 2 && p == mpix) begin
                repeat (d - 1) emit(P_WAIT);
                dn_a[t] = 1'b1;
                ab_a[t] = 1'b1;
                emit(P_WAIT);
                return;
            end
            if (d < 1 || d > TO) begin
                repeat (TO) emit(P_WAIT);
                m_terr = 1'b1;
                return;
            end
            repeat (d - 1) emit(P_WAIT);
            dn_a[t] = 1'b1;
            emit(P_WAIT);
            if (p == NPIX - 1) begin
                emit(P_DONE);
            end else if (m_col < NC - 1) begin
                repeat (PUL) emit(P_COL);
                m_col++;
            end else begin
                if (mode == 1 && p == mpix) begin
                    ab_a[t] = 1'b1;
                    emit(P_ROW);
                    return;
                end
                repeat (PUL) emit(P_ROW);
                m_col = 0;
                m_row++;
            end
        end
    endtask

    function automatic logic [27:0] expv(int ph, int r, int c, bit te);
        logic [2:0] s;
        s = 3'(ph);
        return {s, 8'(r), 8'(c), ph == P_RST, ph == P_RST, ph == P_COL,
                ph == P_ROW, (ph == P_SET || ph == P_CONV || ph == P_WAIT),
                ph == P_CONV, ph != P_IDLE, ph == P_DONE, te};
    endfunction

    initial begin
        int T, n_as, n_incp, n_incv, n_fd, first_as;
        bit p_incp, p_incv, p_fd;
        logic [27:0] obs, exv;

        reset = 1'b1; start_cap = 1'b0; abort = 1'b0;
        fifo_afull = 1'b0; adc_done = 1'b0;
        n_assert = 0; n_fail = 0;
        t = 0; m_row = 0; m_col = 0; m_terr = 1'b0; noise = 1'b0;

        rs_a[0] = 1'b1; rs_a[1] = 1'b1;
        idle(4);

        // clean frame: adc_done two cycles after every adc_start
        foreach (dly[i]) dly[i] = 2;
        f1_s = t;
        gen_frame(0, 0, -1);
        f1_e = t;
        idle(4);
        for (int i = t; i < MAXT; i++) af_a[i] = ($urandom_range(5) == 0);

        noise = 1'b1;
        foreach (dly[i]) dly[i] = $urandom_range(1, 4);
        dly[4] = TO;
        gen_frame(0, 0, 1);
        idle(3);

        foreach (dly[i]) dly[i] = 2;
        dly[2] = 0;
        gen_frame(0, 0, -1);
        idle(5);

        foreach (dly[i]) dly[i] = $urandom_range(1, 4);
        gen_frame(1, 2, -1);
        idle(3);
        foreach (dly[i]) dly[i] = $urandom_range(1, 4);
        gen_frame(2, 4, -1);
        idle(3);
        gen_frame(3, 3, -1);
        idle(3);
        foreach (dly[i]) dly[i] = $urandom_range(1, TO);
        gen_frame(0, 0, -1);
        idle(3);
        T = (t < MAXT) ? t : MAXT;

        n_as = 0; n_incp = 0; n_incv = 0; n_fd = 0; first_as = -1;
        p_incp = 1'b0; p_incv = 1'b0; p_fd = 1'b0;

        repeat (3) @(posedge clk);
        for (int c = 0; c < T; c++) begin
            #1;
            reset      = rs_a[c];
            start_cap  = st_a[c];
            abort      = ab_a[c];
            fifo_afull = af_a[c];
            adc_done   = dn_a[c];
            @(negedge clk);

            obs = {state_out, row_idx, col_idx, resp, resv, incp, incv,
                   inphi, adc_start, busy, frame_done, timeout_err};
            exv = expv(ex_ph[c], ex_row[c], ex_col[c], ex_terr[c]);
            n_assert++;
            assert (obs === exv) else begin
                n_fail++;
                $error("FAIL trace cyc=%0d observed=%h expected=%h",
                       c, obs, exv);
            end

            if (c > f1_s && c < f1_e) begin
                if (adc_start) n_as++;
                if (adc_start && first_as < 0) first_as = c;
                if (incp && !p_incp) n_incp++;
                if (incv && !p_incv) n_incv++;
                if (frame_done) n_fd++;
            end
            if (c == f1_s + 1 || c == f1_s + 2) begin
                n_assert++;
                assert ((resp & resv) === 1'b1) else begin
                    n_fail++;
                    $error("FAIL resp_resv cyc=%0d observed=%b%b expected=11",
                           c, resp, resv);
                end
            end
            if (c == f1_e) begin
                n_assert++;
                assert (n_as === NPIX) else begin
                    n_fail++;
                    $error("FAIL adc_start_count observed=%0d expected=%0d",
                           n_as, NPIX);
                end
                n_assert++;
                assert (n_incp === (NC - 1) * NR) else begin
                    n_fail++;
                    $error("FAIL incp_count observed=%0d expected=%0d",
                           n_incp, (NC - 1) * NR);
                end
                n_assert++;
                assert (n_incv === NR - 1) else begin
                    n_fail++;
                    $error("FAIL incv_count observed=%0d expected=%0d",
                           n_incv, NR - 1);
                end
                n_assert++;
                assert (n_fd === 1) else begin
                    n_fail++;
                    $error("FAIL frame_done_count observed=%0d expected=1",
                           n_fd);
                end
                n_assert++;
                assert (first_as === f1_s + 7) else begin
                    n_fail++;
                    $error("FAIL first_adc_start observed=%0d expected=%0d",
                           first_as, f1_s + 7);
                end
                n_assert++;
                assert ({p_fd, busy} === 2'b10) else begin
                    n_fail++;
                    $error("FAIL busy_after_done observed=%b%b expected=10",
                           p_fd, busy);
                end
            end
            p_incp = incp;
            p_incv = incv;
            p_fd   = frame_done;
            @(posedge clk);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
